// File: rtl/interrupt_controller.sv
// interrupt_controller: 8-source priority interrupt controller with req/ack/done handshake and 4-byte register window.
// Define IRQ_NESTING_EN to let a higher-priority source preempt one already in service.
module interrupt_controller #(
    parameter logic [7:0] IRQ_CTRL_ADDRESS = 8'h10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic [7:0] address,
    input  logic       w_en,
    input  logic       r_en,
    output logic [7:0] dout,
    input  logic [7:0] irq_src,
    output logic [7:0] irq_clr,
    output logic       irq,
    output logic [2:0] irq_vector,
    input  logic       irq_ack,
    input  logic       irq_done
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t     state_q, state_d;
    logic [7:0] enable_q, enable_d, isr_q, isr_d, clr_q, clr_d, dout_q, dout_d;
    logic [7:0] pend, off, isr_dn;
    logic [3:0] best, low_dn;
    logic [2:0] vec_q, vec_d;
    logic       gie_q, gie_d, irq_q, irq_d, hit, wr, ack_ok, done_ok, preempt;

    // Index of the lowest set bit, 8 when none.
    function automatic logic [3:0] lsb(input logic [7:0] v);
        lsb = 4'd8;
        for (int i = 7; i >= 0; i--)
            if (v[i]) lsb = i[3:0];
    endfunction

    always_comb begin
        pend     = irq_src & enable_q;
        best     = lsb(pend);
        off      = address - IRQ_CTRL_ADDRESS;
        hit      = off < 8'd4;
        wr       = w_en && hit;
        enable_d = (wr && off == 8'd0) ? din : enable_q;
        gie_d    = (wr && off == 8'd2) ? din[0] : gie_q;
        dout_d   = !(r_en && hit) ? dout_q :
                   off == 8'd0 ? enable_q :
                   off == 8'd1 ? pend :
                   off == 8'd2 ? {7'd0, gie_q} : isr_q;
        done_ok  = irq_done && isr_q != 8'd0;
`ifdef IRQ_NESTING_EN
        // Done retires the lowest (most urgent) in-service bit before any ack at the same edge.
        isr_dn   = done_ok ? (isr_q & (isr_q - 8'd1)) : isr_q;
        low_dn   = lsb(isr_dn);
        ack_ok   = irq_ack && irq_q && pend != 8'd0 && best < low_dn;
`else
        isr_dn   = done_ok ? (isr_q & ~(8'd1 << vec_q)) : isr_q;
        low_dn   = lsb(isr_dn);
        ack_ok   = irq_ack && irq_q && pend != 8'd0;
`endif
        isr_d    = ack_ok ? (isr_dn | (8'd1 << best[2:0])) : isr_dn;
`ifdef IRQ_NESTING_EN
        vec_d    = ack_ok ? best[2:0] : done_ok ? (low_dn[3] ? 3'd0 : low_dn[2:0]) : vec_q;
`else
        vec_d    = ack_ok ? best[2:0] : vec_q;
`endif
        clr_d    = ((wr && off == 8'd1) ? din : 8'd0) | (ack_ok ? (8'd1 << best[2:0]) : 8'd0);
        state_d  = state_q;
        if (state_q == IDLE)
            state_d = (gie_q && pend != 8'd0) ? REQ : IDLE;
        else if (state_q == REQ)
            state_d = ack_ok ? SERVICE : (!gie_q || pend == 8'd0) ? IDLE : REQ;
        else if (done_ok || ack_ok)
            state_d = isr_d != 8'd0 ? SERVICE : IDLE;
`ifdef IRQ_NESTING_EN
        preempt  = state_d == SERVICE && gie_q && pend != 8'd0 && best < lsb(isr_d);
`else
        preempt  = 1'b0;
`endif
        irq_d    = state_d == REQ || preempt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            enable_q <= 8'd0;
            gie_q    <= 1'b0;
            isr_q    <= 8'd0;
            vec_q    <= 3'd0;
            clr_q    <= 8'd0;
            dout_q   <= 8'd0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            gie_q    <= gie_d;
            isr_q    <= isr_d;
            vec_q    <= vec_d;
            clr_q    <= clr_d;
            dout_q   <= dout_d;
            irq_q    <= irq_d;
        end
    end

    assign dout       = dout_q;
    assign irq_clr    = clr_q;
    assign irq        = irq_q;
    assign irq_vector = vec_q;
endmodule
